// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions: instruction encodings, hazard FSM states and
// forwarding-select codes used by the hazard scoreboard and its helpers.
package hazard_scoreboard_pkg;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 2;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_OPIMM  = 7'b0010011,
    OP_OP     = 7'b0110011
  } opcode_t;

  typedef struct packed {
    opcode_t           opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              reg_write;
    logic              is_load;
  } instr_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_WAIT  = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_t;

  // Counters stop at zero rather than wrapping to the maximum value.
  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] res;
    if (cnt == 2'd0) begin
      res = 2'd0;
    end else begin
      res = cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd_match.sv
// Per-source operand comparison: picks the youngest in-flight producer and
// flags a hit on a load still sitting in EX.
module fwd_match
  import hazard_scoreboard_pkg::*;
(
  input  logic [REG_AW-1:0] rs_addr,
  input  logic              rs_used,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic              ex_reg_write,
  input  logic              mem_reg_write,
  input  logic              wb_reg_write,
  input  logic              ex_is_load,
  output fwd_sel_t          fwd_sel,
  output logic              load_hit
);

  // Priority EX > MEM > WB; x0 is hard-wired zero and never forwards.
  always_comb begin
    fwd_sel  = FWD_RF;
    load_hit = 1'b0;
    if (rs_used && (rs_addr != 5'd0)) begin
      if (ex_reg_write && (rs_addr == ex_rd_addr)) begin
        fwd_sel  = FWD_EX;
        load_hit = ex_is_load;
      end else if (mem_reg_write && (rs_addr == mem_rd_addr)) begin
        fwd_sel = FWD_MEM;
      end else if (wb_reg_write && (rs_addr == wb_rd_addr)) begin
        fwd_sel = FWD_WB;
      end else begin
        fwd_sel = FWD_RF;
      end
    end else begin
      fwd_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: operand forwarding selects plus a small FSM that
// sequences load-use stalls, memory-wait holds and redirect flushes.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_LEN = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC-1:0][REG_AW-1:0] dec_rs_addr,
  input  logic [NUM_SRC-1:0]             dec_rs_used,
  input  logic [REG_AW-1:0]              ex_rd_addr,
  input  logic [REG_AW-1:0]              mem_rd_addr,
  input  logic [REG_AW-1:0]              wb_rd_addr,
  input  logic                           ex_regWrite,
  input  logic                           mem_regWrite,
  input  logic                           wb_regWrite,
  input  logic                           ex_is_load,
  input  logic                           mem_ready,
  input  logic                           redirect,
  output logic [NUM_SRC-1:0][1:0]        fwd_sel,
  output logic                           stall,
  output logic                           ex_bubble,
  output logic                           if_flush,
  output logic                           dec_flush,
  output logic [1:0]                     state
);

  localparam logic [CNT_W-1:0] LD_INIT = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] FL_INIT = CNT_W'(FLUSH_LEN - 1);

  state_t           state_q, state_d;
  state_t           saved_q, saved_d;
  logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;
  logic [NUM_SRC-1:0] load_hit_s;
  logic               load_use_s;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    fwd_sel_t sel_s;
    fwd_match u_match (
      .rs_addr       (dec_rs_addr[gi]),
      .rs_used       (dec_rs_used[gi]),
      .ex_rd_addr    (ex_rd_addr),
      .mem_rd_addr   (mem_rd_addr),
      .wb_rd_addr    (wb_rd_addr),
      .ex_reg_write  (ex_regWrite),
      .mem_reg_write (mem_regWrite),
      .wb_reg_write  (wb_regWrite),
      .ex_is_load    (ex_is_load),
      .fwd_sel       (sel_s),
      .load_hit      (load_hit_s[gi])
    );
    assign fwd_sel[gi] = sel_s;
  end

  // Several sources hitting the same load still yield a single stall sequence.
  assign load_use_s = |load_hit_s;
  assign state      = state_q;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      saved_q  <= ST_RUN;
      ld_cnt_q <= 2'd0;
      fl_cnt_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      saved_q  <= saved_d;
      ld_cnt_q <= ld_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

  // Next state: memory hold freezes everything, then redirect, then load-use.
  always_comb begin
    state_d  = state_q;
    saved_d  = saved_q;
    ld_cnt_d = ld_cnt_q;
    fl_cnt_d = fl_cnt_q;
    if (!mem_ready) begin
      state_d = ST_MEM_WAIT;
      if (state_q != ST_MEM_WAIT) begin
        saved_d = state_q;
      end else begin
        saved_d = saved_q;
      end
    end else if (state_q == ST_MEM_WAIT) begin
      state_d = saved_q;
    end else if (redirect) begin
      ld_cnt_d = 2'd0;
      fl_cnt_d = FL_INIT;
      state_d  = (FLUSH_LEN > 1) ? ST_FLUSH : ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (load_use_s) begin
            ld_cnt_d = LD_INIT;
            state_d  = (LOAD_LAT > 1) ? ST_LD_WAIT : ST_RUN;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_LD_WAIT: begin
          ld_cnt_d = sat_dec(ld_cnt_q);
          state_d  = (ld_cnt_q <= 2'd1) ? ST_RUN : ST_LD_WAIT;
        end
        ST_FLUSH: begin
          fl_cnt_d = sat_dec(fl_cnt_q);
          state_d  = (fl_cnt_q <= 2'd1) ? ST_RUN : ST_FLUSH;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // Control outputs for the current cycle; reset silences all of them.
  always_comb begin
    stall     = 1'b0;
    ex_bubble = 1'b0;
    if_flush  = 1'b0;
    dec_flush = 1'b0;
    if (rst) begin
      stall = 1'b0;
    end else if (!mem_ready || (state_q == ST_MEM_WAIT)) begin
      stall = 1'b1;
    end else if (redirect) begin
      if_flush  = 1'b1;
      dec_flush = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          stall     = load_use_s;
          ex_bubble = load_use_s;
        end
        ST_LD_WAIT: begin
          stall     = (ld_cnt_q != 2'd0);
          ex_bubble = (ld_cnt_q != 2'd0);
        end
        ST_FLUSH: begin
          if_flush  = 1'b1;
          dec_flush = 1'b1;
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench: two parameterisations share one stimulus stream,
// expectations are queued on drive and compared before the next clock edge.
module tb_hazard_scoreboard;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0][4:0] rs_addr;
  logic [1:0]      rs_used;
  logic [4:0]      ex_rd, mem_rd, wb_rd;
  logic            ex_rw, mem_rw, wb_rw, ex_ld, mem_ready, redirect;

  logic [1:0][1:0] a_fwd, b_fwd;
  logic            a_stall, a_bub, a_ifl, a_dfl;
  logic            b_stall, b_bub, b_ifl, b_dfl;
  logic [1:0]      a_state, b_state;

  int checks = 0;
  int errors = 0;

  // {state, stall, ex_bubble, if_flush, dec_flush}
  localparam logic [5:0] S_IDLE  = 6'b00_0000;
  localparam logic [5:0] S_LU    = 6'b00_1100;
  localparam logic [5:0] S_LDW   = 6'b01_1100;
  localparam logic [5:0] S_FLR   = 6'b00_0011;
  localparam logic [5:0] S_FLF   = 6'b11_0011;
  localparam logic [5:0] S_MWRUN = 6'b00_1000;
  localparam logic [5:0] S_MWLD  = 6'b01_1000;
  localparam logic [5:0] S_MW    = 6'b10_1000;
  localparam logic [5:0] S_RLD   = 6'b01_0000;
  localparam logic [5:0] S_RMW   = 6'b10_0000;
  localparam logic [5:0] S_RFL   = 6'b11_0000;

  typedef struct {
    string      tag;
    int         dut;
    logic [9:0] exp;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  hazard_scoreboard #(.NUM_SRC(2), .LOAD_LAT(1), .FLUSH_LEN(1)) dut_a (
    .clk(clk), .rst(rst), .dec_rs_addr(rs_addr), .dec_rs_used(rs_used),
    .ex_rd_addr(ex_rd), .mem_rd_addr(mem_rd), .wb_rd_addr(wb_rd),
    .ex_regWrite(ex_rw), .mem_regWrite(mem_rw), .wb_regWrite(wb_rw),
    .ex_is_load(ex_ld), .mem_ready(mem_ready), .redirect(redirect),
    .fwd_sel(a_fwd), .stall(a_stall), .ex_bubble(a_bub),
    .if_flush(a_ifl), .dec_flush(a_dfl), .state(a_state)
  );

  hazard_scoreboard #(.NUM_SRC(2), .LOAD_LAT(3), .FLUSH_LEN(2)) dut_b (
    .clk(clk), .rst(rst), .dec_rs_addr(rs_addr), .dec_rs_used(rs_used),
    .ex_rd_addr(ex_rd), .mem_rd_addr(mem_rd), .wb_rd_addr(wb_rd),
    .ex_regWrite(ex_rw), .mem_regWrite(mem_rw), .wb_regWrite(wb_rw),
    .ex_is_load(ex_ld), .mem_ready(mem_ready), .redirect(redirect),
    .fwd_sel(b_fwd), .stall(b_stall), .ex_bubble(b_bub),
    .if_flush(b_ifl), .dec_flush(b_dfl), .state(b_state)
  );

  task automatic drv(input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] used,
                     input logic [4:0] exd, input logic exw, input logic exl,
                     input logic [4:0] md, input logic mw, input logic [4:0] wd, input logic ww,
                     input logic mr, input logic rd);
    rs_addr[0] = r0;  rs_addr[1] = r1;  rs_used = used;
    ex_rd = exd;  ex_rw = exw;  ex_ld = exl;
    mem_rd = md;  mem_rw = mw;  wb_rd = wd;  wb_rw = ww;
    mem_ready = mr;  redirect = rd;
  endtask

  task automatic idle();
    drv(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic exp2(input string tag, input logic [5:0] ea, input logic [5:0] eb,
                      input logic [3:0] fw);
    exp_t e;
    e.tag = tag;  e.dut = 0;  e.exp = {ea, fw};  sb_q.push_back(e);
    e.dut = 1;    e.exp = {eb, fw};              sb_q.push_back(e);
  endtask

  task automatic step();
    exp_t       e;
    logic [9:0] o;
    #3;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      if (e.dut == 0) o = {a_state, a_stall, a_bub, a_ifl, a_dfl, a_fwd};
      else            o = {b_state, b_stall, b_bub, b_ifl, b_dfl, b_fwd};
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s dut%0d observed=%b expected=%b", e.tag, e.dut, o, e.exp);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);

    // Reset silences a live load-use; forwarding stays combinational.
    drv(5'd5, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    exp2("reset_forces_zero", S_IDLE, S_IDLE, 4'b0001);  step();
    rst = 1'b0;

    // Load-use: one stall for LOAD_LAT=1, three for LOAD_LAT=3.
    drv(5'd5, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    exp2("lu_detect", S_LU, S_LU, 4'b0001);  step();
    drv(5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
    exp2("lu_fwd_mem", S_IDLE, S_LDW, 4'b0010);  step();
    drv(5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    exp2("lu_fwd_wb", S_IDLE, S_LDW, 4'b0011);  step();
    idle();
    exp2("lu_release", S_IDLE, S_IDLE, 4'b0000);  step();

    // Forwarding: x0 never forwards, EX beats MEM, MEM beats WB, unused ignored.
    drv(5'd0, 5'd0, 2'b01, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    exp2("fwd_x0", S_IDLE, S_IDLE, 4'b0000);  step();
    drv(5'd0, 5'd7, 2'b11, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
    exp2("fwd_ex_over_mem", S_IDLE, S_IDLE, 4'b0100);  step();
    drv(5'd9, 5'd9, 2'b01, 5'd9, 1'b0, 1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0);
    exp2("fwd_mem_over_wb", S_IDLE, S_IDLE, 4'b0010);  step();

    // Both sources on the same load: still a single three-cycle sequence.
    drv(5'd4, 5'd4, 2'b11, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    exp2("dual_src_lu", S_LU, S_LU, 4'b0101);  step();
    idle();
    exp2("dual_src_w1", S_IDLE, S_LDW, 4'b0000);  step();
    exp2("dual_src_w2", S_IDLE, S_LDW, 4'b0000);  step();
    exp2("dual_src_end", S_IDLE, S_IDLE, 4'b0000);  step();

    // Redirect cancels load-use; FLUSH suppresses load-use detection.
    drv(5'd5, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    exp2("redir_cancel_lu", S_FLR, S_FLR, 4'b0001);  step();
    drv(5'd6, 5'd0, 2'b01, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    exp2("flush_suppress_lu", S_LU, S_FLF, 4'b0001);  step();
    idle();
    exp2("flush_end", S_IDLE, S_IDLE, 4'b0000);  step();

    // A second redirect while flushing reloads the flush counter.
    drv(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    exp2("redir_first", S_FLR, S_FLR, 4'b0000);  step();
    exp2("redir_reload", S_FLR, S_FLF, 4'b0000);  step();
    idle();
    exp2("reload_tail", S_IDLE, S_FLF, 4'b0000);  step();
    exp2("reload_end", S_IDLE, S_IDLE, 4'b0000);  step();

    // Memory wait in the middle of LD_WAIT freezes the remaining count.
    drv(5'd5, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    exp2("mw_lu", S_LU, S_LU, 4'b0001);  step();
    drv(5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
    exp2("mw_ldw", S_IDLE, S_LDW, 4'b0010);  step();
    drv(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    exp2("mw_enter", S_MWRUN, S_MWLD, 4'b0000);  step();
    for (int i = 0; i < 3; i++) begin
      exp2("mw_hold", S_MW, S_MW, 4'b0000);  step();
    end
    idle();
    exp2("mw_exit", S_MW, S_MW, 4'b0000);  step();
    exp2("mw_resume", S_IDLE, S_LDW, 4'b0000);  step();
    exp2("mw_done", S_IDLE, S_IDLE, 4'b0000);  step();

    // Reset abandons FLUSH, LD_WAIT and MEM_WAIT sequences.
    drv(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    exp2("rst_fl_redir", S_FLR, S_FLR, 4'b0000);  step();
    idle();  rst = 1'b1;
    exp2("rst_in_flush", S_IDLE, S_RFL, 4'b0000);  step();
    rst = 1'b0;
    exp2("rst_fl_after", S_IDLE, S_IDLE, 4'b0000);  step();

    drv(5'd5, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    exp2("rst_ld_lu", S_LU, S_LU, 4'b0001);  step();
    idle();  rst = 1'b1;
    exp2("rst_in_ldwait", S_IDLE, S_RLD, 4'b0000);  step();
    rst = 1'b0;
    exp2("rst_ld_after", S_IDLE, S_IDLE, 4'b0000);  step();

    // Memory wait outranks a redirect in the same cycle.
    drv(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    exp2("mw_over_redir", S_MWRUN, S_MWRUN, 4'b0000);  step();
    rst = 1'b1;
    exp2("rst_in_memwait", S_RMW, S_RMW, 4'b0000);  step();
    rst = 1'b0;  idle();
    exp2("rst_mw_after", S_IDLE, S_IDLE, 4'b0000);  step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
